// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared pipeline definitions: controller states and register-index constants.
package pipe_hazard_ctrl_pkg;

    localparam int unsigned REG_IDX_W = 5;
    localparam logic [REG_IDX_W-1:0] REG_ZERO = 5'd0;

    // RUN: pipeline flows; WAIT: a data-memory access is outstanding.
    typedef enum logic {
        StRun  = 1'b0,
        StWait = 1'b1
    } ctrlStateT;

endpackage

// File: rtl/pipe_hazard_ctrl_hazard_detect.sv
// Combinational load-use detection between the ID instruction and a load in EX.
module hazard_detect
    import pipe_hazard_ctrl_pkg::*;
(
    input  logic [REG_IDX_W-1:0] IdRs1In,
    input  logic [REG_IDX_W-1:0] IdRs2In,
    input  logic                 IdUsesRs1In,
    input  logic                 IdUsesRs2In,
    input  logic [REG_IDX_W-1:0] ExRdIn,
    input  logic                 ExMemReadIn,
    output logic                 LoadUseOut
);

    // A load writing x0 never creates a dependency.
    always_comb begin
        LoadUseOut = ExMemReadIn && (ExRdIn != REG_ZERO) &&
                     ((IdUsesRs1In && (IdRs1In == ExRdIn)) ||
                      (IdUsesRs2In && (IdRs2In == ExRdIn)));
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencing controller: stalls, squashes, memory waits and perf counters.
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int unsigned CNT_W   = 16,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic                 clkIn,
    input  logic                 resetIn,
    input  logic [REG_IDX_W-1:0] IdRs1In,
    input  logic [REG_IDX_W-1:0] IdRs2In,
    input  logic                 IdUsesRs1In,
    input  logic                 IdUsesRs2In,
    input  logic [REG_IDX_W-1:0] ExRdIn,
    input  logic                 ExMemReadIn,
    input  logic                 ExBranchTakenIn,
    input  logic                 DMemReqIn,
    input  logic                 DMemAckIn,
    output logic                 PcWriteOut,
    output logic                 IfIdWriteOut,
    output logic                 IfIdFlushOut,
    output logic                 IdExWriteOut,
    output logic                 IdExFlushOut,
    output logic                 ExMemWriteOut,
    output logic                 MemWbWriteOut,
    output logic [CNT_W-1:0]     StallCntOut,
    output logic [CNT_W-1:0]     FlushCntOut,
    output logic                 MemErrOut
);

    localparam logic [CNT_W-1:0] WcntInit = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CntMax   = '1;

    ctrlStateT        stateQ, stateD;
    logic [CNT_W-1:0] wcntQ, wcntD;
    logic [CNT_W-1:0] stallCntQ, flushCntQ;
    logic             memErrQ;
    logic             loadUse;
    logic             hold;
    logic             timeout;
    logic             branchWin;

    hazard_detect uHazardDetect (
        .IdRs1In     (IdRs1In),
        .IdRs2In     (IdRs2In),
        .IdUsesRs1In (IdUsesRs1In),
        .IdUsesRs2In (IdUsesRs2In),
        .ExRdIn      (ExRdIn),
        .ExMemReadIn (ExMemReadIn),
        .LoadUseOut  (loadUse)
    );

    // Freeze conditions: an unacknowledged access, bounded by the wait counter.
    always_comb begin
        hold    = 1'b0;
        timeout = 1'b0;
        unique case (stateQ)
            StRun:  hold = DMemReqIn && !DMemAckIn;
            StWait: begin
                hold    = !DMemAckIn && (wcntQ != '0);
                timeout = !DMemAckIn && (wcntQ == '0);
            end
            default: ;
        endcase
    end

    // Prioritised pipeline-register controls; everything quiet while in reset.
    always_comb begin
        PcWriteOut    = 1'b0;
        IfIdWriteOut  = 1'b0;
        IfIdFlushOut  = 1'b0;
        IdExWriteOut  = 1'b0;
        IdExFlushOut  = 1'b0;
        ExMemWriteOut = 1'b0;
        MemWbWriteOut = 1'b0;
        branchWin     = 1'b0;
        if (resetIn && !hold) begin
            PcWriteOut    = 1'b1;
            IfIdWriteOut  = 1'b1;
            IdExWriteOut  = 1'b1;
            ExMemWriteOut = 1'b1;
            MemWbWriteOut = 1'b1;
            if (ExBranchTakenIn) begin
                // The ID instruction is squashed anyway, so load-use is moot.
                branchWin    = 1'b1;
                IfIdFlushOut = 1'b1;
                IdExFlushOut = 1'b1;
            end else if (loadUse) begin
                PcWriteOut   = 1'b0;
                IfIdWriteOut = 1'b0;
                IdExFlushOut = 1'b1;
            end
        end
    end

    // Next state and wait-counter sequencing.
    always_comb begin
        stateD = stateQ;
        wcntD  = wcntQ;
        unique case (stateQ)
            StRun: begin
                if (DMemReqIn && !DMemAckIn) begin
                    stateD = StWait;
                    wcntD  = WcntInit;
                end
            end
            StWait: begin
                if (DMemAckIn) begin
                    stateD = StRun;
                end else if (wcntQ != '0) begin
                    wcntD = wcntQ - CNT_W'(1);
                end else begin
                    stateD = StRun;
                end
            end
            default: stateD = StRun;
        endcase
    end

    // State, saturating counters and sticky error flag.
    always_ff @(posedge clkIn or negedge resetIn) begin
        if (!resetIn) begin
            stateQ    <= StRun;
            wcntQ     <= '0;
            stallCntQ <= '0;
            flushCntQ <= '0;
            memErrQ   <= 1'b0;
        end else begin
            stateQ <= stateD;
            wcntQ  <= wcntD;
            if (!PcWriteOut && (stallCntQ != CntMax)) begin
                stallCntQ <= stallCntQ + CNT_W'(1);
            end
            if (branchWin && (flushCntQ != CntMax)) begin
                flushCntQ <= flushCntQ + CNT_W'(1);
            end
            if (timeout) begin
                memErrQ <= 1'b1;
            end
        end
    end

    assign StallCntOut = stallCntQ;
    assign FlushCntOut = flushCntQ;
    assign MemErrOut   = memErrQ;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl with an access-level behavioural model.
module tb_pipe_hazard_ctrl;

    localparam int unsigned CNT_W   = 4;
    localparam int unsigned TIMEOUT = 4;
    localparam int          MAX_CNT = (1 << CNT_W) - 1;

    localparam logic [6:0] O_HOLD   = 7'b0000000;
    localparam logic [6:0] O_NORMAL = 7'b1101011;
    localparam logic [6:0] O_LOAD   = 7'b0001111;
    localparam logic [6:0] O_BRANCH = 7'b1111111;

    logic clkIn = 1'b0;
    logic resetIn;
    logic [4:0] IdRs1In, IdRs2In, ExRdIn;
    logic IdUsesRs1In, IdUsesRs2In, ExMemReadIn, ExBranchTakenIn, DMemReqIn, DMemAckIn;
    logic PcWriteOut, IfIdWriteOut, IfIdFlushOut, IdExWriteOut, IdExFlushOut;
    logic ExMemWriteOut, MemWbWriteOut, MemErrOut;
    logic [CNT_W-1:0] StallCntOut, FlushCntOut;
    logic [6:0] dutOut;

    int testsRun = 0;
    int testsFailed = 0;

    always #5 clkIn = ~clkIn;

    pipe_hazard_ctrl #(
        .CNT_W   (CNT_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clkIn           (clkIn),
        .resetIn         (resetIn),
        .IdRs1In         (IdRs1In),
        .IdRs2In         (IdRs2In),
        .IdUsesRs1In     (IdUsesRs1In),
        .IdUsesRs2In     (IdUsesRs2In),
        .ExRdIn          (ExRdIn),
        .ExMemReadIn     (ExMemReadIn),
        .ExBranchTakenIn (ExBranchTakenIn),
        .DMemReqIn       (DMemReqIn),
        .DMemAckIn       (DMemAckIn),
        .PcWriteOut      (PcWriteOut),
        .IfIdWriteOut    (IfIdWriteOut),
        .IfIdFlushOut    (IfIdFlushOut),
        .IdExWriteOut    (IdExWriteOut),
        .IdExFlushOut    (IdExFlushOut),
        .ExMemWriteOut   (ExMemWriteOut),
        .MemWbWriteOut   (MemWbWriteOut),
        .StallCntOut     (StallCntOut),
        .FlushCntOut     (FlushCntOut),
        .MemErrOut       (MemErrOut)
    );

    assign dutOut = {PcWriteOut, IfIdWriteOut, IfIdFlushOut, IdExWriteOut, IdExFlushOut,
                     ExMemWriteOut, MemWbWriteOut};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        testsRun++;
        if (act !== exp) begin
            testsFailed++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: an access is outstanding after an unacked request; it may be held at most
    // TIMEOUT cycles in total, after which it is abandoned with an error.
    bit mInAccess = 1'b0;
    int mHeld = 0;
    int mStall = 0;
    int mFlush = 0;
    bit mErr = 1'b0;

    function automatic bit mLoadUse();
        return ExMemReadIn && (ExRdIn != 5'd0) &&
               ((IdUsesRs1In && IdRs1In == ExRdIn) || (IdUsesRs2In && IdRs2In == ExRdIn));
    endfunction

    function automatic bit mHold();
        if (!mInAccess) return DMemReqIn && !DMemAckIn;
        return !DMemAckIn && (mHeld < int'(TIMEOUT));
    endfunction

    function automatic logic [6:0] mOut();
        if (resetIn !== 1'b1 || mHold()) return O_HOLD;
        if (ExBranchTakenIn) return O_BRANCH;
        if (mLoadUse()) return O_LOAD;
        return O_NORMAL;
    endfunction

    always @(posedge clkIn or negedge resetIn) begin
        bit h;
        logic [6:0] o;
        if (!resetIn) begin
            mInAccess <= 1'b0;
            mHeld     <= 0;
            mStall    <= 0;
            mFlush    <= 0;
            mErr      <= 1'b0;
        end else begin
            h = mHold();
            o = mOut();
            if (!o[6] && mStall < MAX_CNT) mStall <= mStall + 1;
            if (!h && ExBranchTakenIn && mFlush < MAX_CNT) mFlush <= mFlush + 1;
            if (!mInAccess) begin
                if (h) begin
                    mInAccess <= 1'b1;
                    mHeld     <= 1;
                end
            end else if (DMemAckIn) begin
                mInAccess <= 1'b0;
            end else if (h) begin
                mHeld <= mHeld + 1;
            end else begin
                mInAccess <= 1'b0;
                mErr      <= 1'b1;
            end
        end
    end

    // Every falling edge: DUT against model.
    always @(negedge clkIn) begin
        check("outs", 32'(dutOut), 32'(mOut()));
        check("stallCnt", 32'(StallCntOut), 32'(mStall));
        check("flushCnt", 32'(FlushCntOut), 32'(mFlush));
        check("memErr", 32'(MemErrOut), 32'(mErr));
    end

    task automatic setIn(input logic [4:0] rs1, input logic [4:0] rs2, input logic u1,
                         input logic u2, input logic [4:0] rd, input logic ld,
                         input logic br, input logic req, input logic ack);
        IdRs1In = rs1; IdRs2In = rs2; IdUsesRs1In = u1; IdUsesRs2In = u2;
        ExRdIn = rd; ExMemReadIn = ld; ExBranchTakenIn = br;
        DMemReqIn = req; DMemAckIn = ack;
    endtask

    // Apply a vector just after a rising edge; literal checks follow 1 time unit later.
    task automatic step(input logic [4:0] rs1, input logic [4:0] rs2, input logic u1,
                        input logic u2, input logic [4:0] rd, input logic ld,
                        input logic br, input logic req, input logic ack);
        @(posedge clkIn);
        #1;
        setIn(rs1, rs2, u1, u2, rd, ld, br, req, ack);
        #1;
    endtask

    task automatic stepClear();
        step(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic stepLoadUse();
        step(5'd1, 5'd5, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        resetIn = 1'b0;
        setIn(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        #2;
        check("reset_outs", 32'(dutOut), 32'(O_HOLD));
        check("reset_stall", 32'(StallCntOut), 32'd0);
        check("reset_err", 32'(MemErrOut), 32'd0);
        @(posedge clkIn);
        #1 resetIn = 1'b1;

        stepClear();
        check("normal", 32'(dutOut), 32'(O_NORMAL));

        // Load-use: one bubble, one stall count.
        stepLoadUse();
        check("loaduse_outs", 32'(dutOut), 32'(O_LOAD));
        check("loaduse_stall0", 32'(StallCntOut), 32'd0);
        stepClear();
        check("loaduse_release", 32'(dutOut), 32'(O_NORMAL));
        check("loaduse_stall1", 32'(StallCntOut), 32'd1);

        // A load to x0 never stalls.
        step(5'd0, 5'd0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        check("x0_outs", 32'(dutOut), 32'(O_NORMAL));
        stepClear();
        check("x0_stall", 32'(StallCntOut), 32'd1);

        // Branch wins over load-use.
        step(5'd1, 5'd5, 1'b0, 1'b1, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0);
        check("branch_outs", 32'(dutOut), 32'(O_BRANCH));
        stepClear();
        check("branch_flush", 32'(FlushCntOut), 32'd1);
        check("branch_stall", 32'(StallCntOut), 32'd1);

        // Memory wait: three held cycles, released on the ack.
        for (int i = 0; i < 3; i++) begin
            step(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
            check("memwait_hold", 32'(dutOut), 32'(O_HOLD));
        end
        step(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
        check("memwait_release", 32'(dutOut), 32'(O_NORMAL));
        check("memwait_stall", 32'(StallCntOut), 32'd4);
        stepClear();
        check("memwait_err", 32'(MemErrOut), 32'd0);

        // Timeout: TIMEOUT held cycles, then release with a sticky error.
        for (int i = 0; i < 5; i++) begin
            step(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
            check("timeout_outs", 32'(dutOut), 32'(i < 4 ? O_HOLD : O_NORMAL));
        end
        check("timeout_err_pre", 32'(MemErrOut), 32'd0);
        stepClear();
        check("timeout_err", 32'(MemErrOut), 32'd1);
        check("timeout_stall", 32'(StallCntOut), 32'd8);
        stepClear();
        stepClear();
        check("timeout_err_sticky", 32'(MemErrOut), 32'd1);

        // Asynchronous reset while waiting.
        step(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        step(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        #1 resetIn = 1'b0;
        #1;
        check("areset_outs", 32'(dutOut), 32'(O_HOLD));
        check("areset_stall", 32'(StallCntOut), 32'd0);
        check("areset_err", 32'(MemErrOut), 32'd0);
        setIn(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(posedge clkIn);
        #1 resetIn = 1'b1;
        #1;
        check("areset_run", 32'(dutOut), 32'(O_NORMAL));
        stepClear();

        // Stall counter saturation.
        for (int i = 0; i < 20; i++) stepLoadUse();
        stepClear();
        check("sat_stall", 32'(StallCntOut), 32'd15);

        // Branch is ignored under hold, honoured on the ack cycle.
        step(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0);
        check("holdbr_outs", 32'(dutOut), 32'(O_HOLD));
        step(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b1);
        check("ackbr_outs", 32'(dutOut), 32'(O_BRANCH));
        stepClear();
        check("ackbr_flush", 32'(FlushCntOut), 32'd1);
        stepClear();

        @(posedge clkIn);
        #1;
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
